// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - sequential instruction prefetch FIFO with redirect flush (PREFETCH_STATS_EN adds fetch/drop counters)
module instr_prefetch #(
    parameter logic [31:0] PC_INIT = 32'h80020000,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0] stat_fetches,
    output logic [15:0] stat_drops
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_after;
    logic [31:0]     target;
    logic            push, pop, not_full;

    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    assign target      = redirect_pc & 32'hFFFF_FFFC;
    assign not_full    = count_q < CW'(DEPTH);
    assign instr_valid = count_q != '0;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign mem_req     = state_q != S_IDLE;
    assign mem_addr    = addr_q;
    assign instr_out   = instr_valid ? data_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        push        = 1'b0;
        count_after = count_q;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    addr_d     = target;
                    state_d    = S_REQ;
                end else if (not_full) begin
                    addr_d  = fetch_pc_q;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    // Un-acked request cannot be withdrawn: keep its address until the response is absorbed.
                    if (mem_ack) begin
                        addr_d  = target;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (mem_ack) begin
                    push        = 1'b1;
                    fetch_pc_d  = fetch_pc_q + 32'd4;
                    addr_d      = fetch_pc_q + 32'd4;
                    count_after = pop ? count_q : count_q + CW'(1);
                    state_d     = (count_after < CW'(DEPTH)) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end
                if (mem_ack) begin
                    addr_d  = redirect ? target : fetch_pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= PC_INIT;
            addr_q     <= PC_INIT;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc_q;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic        drop_rsp;
    logic [16:0] fetch_sum, drop_sum;

    assign drop_rsp  = mem_ack & ((state_q == S_REQ & redirect) | (state_q == S_DROP));
    // Flushed entries count as drops alongside the discarded response.
    assign fetch_sum = {1'b0, stat_fetches} + 17'(push);
    assign drop_sum  = {1'b0, stat_drops} + 17'(drop_rsp)
                     + (redirect ? 17'(count_q) : 17'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetches <= 16'h0;
            stat_drops   <= 16'h0;
        end else begin
            stat_fetches <= fetch_sum[16] ? 16'hFFFF : fetch_sum[15:0];
            stat_drops   <= drop_sum[16]  ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule
